// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with rotating-priority write
// arbitration, pending scoreboard and optional write-to-read bypass.
module reg_file_mp #(
  parameter int data_width      = 32,
  parameter int num_regs        = 32,
  parameter int reg_sel_width   = $clog2(num_regs),
  parameter int num_read_ports  = 2,
  parameter int num_write_ports = 2,
  parameter bit bypass          = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [num_read_ports*reg_sel_width-1:0] rd_sel,
  output logic [num_read_ports*data_width-1:0]    rd_data,
  output logic [num_read_ports-1:0]               rd_pending,
  input  logic [num_write_ports-1:0]              wr_req,
  input  logic [num_write_ports*reg_sel_width-1:0] wr_sel,
  input  logic [num_write_ports*data_width-1:0]   wr_data,
  output logic [num_write_ports-1:0]              wr_ack,
  input  logic                                    pend_set,
  input  logic [reg_sel_width-1:0]                pend_sel,
  output logic [num_regs-1:0]                     pending
);

  localparam int NW = num_write_ports;
  localparam int NR = num_read_ports;
  localparam int SW = reg_sel_width;
  localparam int DW = data_width;
  localparam int PW = (NW > 1) ? $clog2(NW) : 1;

  typedef logic [SW-1:0] sel_t;
  typedef logic [DW-1:0] dat_t;

  dat_t          regs [num_regs];
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nxt;
  logic [NW-1:0] elig;
  logic [NW-1:0] grant;
  logic [NW-1:0] contested;
  sel_t          wsel [NW];
  dat_t          wdat [NW];
  int            prio [NW];
  logic          found;
  sel_t          best_sel;
  int            best_p;
  sel_t          rsel [NR];

  // Arbitration: lowest rotated priority wins each same-register group
  always_comb begin
    found    = 1'b0;
    best_sel = '0;
    best_p   = 0;
    rr_nxt   = rr_ptr;
    for (int p = 0; p < NW; p++) begin
      wsel[p] = wr_sel[p*SW +: SW];
      wdat[p] = wr_data[p*DW +: DW];
      elig[p] = wr_req[p] & ~wr_ack[p] & rst;
      if (p >= int'(rr_ptr))
        prio[p] = p - int'(rr_ptr);
      else
        prio[p] = p + NW - int'(rr_ptr);
    end
    for (int p = 0; p < NW; p++) begin
      grant[p]     = elig[p];
      contested[p] = 1'b0;
      for (int q = 0; q < NW; q++) begin
        if (q != p && elig[q] && wsel[q] == wsel[p]) begin
          contested[p] = 1'b1;
          if (prio[q] < prio[p])
            grant[p] = 1'b0;
        end
      end
    end
    for (int p = 0; p < NW; p++) begin
      if (grant[p] && contested[p] &&
          (!found || wsel[p] < best_sel)) begin
        found    = 1'b1;
        best_sel = wsel[p];
        best_p   = p;
      end
    end
    if (found)
      rr_nxt = PW'((best_p + 1) % NW);
  end

  // Read ports: r0 is zero, optional bypass of granted writes
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NR; i++) begin
      rsel[i] = rd_sel[i*SW +: SW];
      rd_data[i*DW +: DW] = regs[rsel[i]];
      if (bypass) begin
        for (int p = 0; p < NW; p++) begin
          if (grant[p] && wsel[p] == rsel[i])
            rd_data[i*DW +: DW] = wdat[p];
        end
      end
      if (rsel[i] == '0)
        rd_data[i*DW +: DW] = '0;
      rd_pending[i] = pending[rsel[i]];
    end
  end

  // Register storage; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < num_regs; r++)
        regs[r] <= '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (grant[p] && wsel[p] != '0)
          regs[wsel[p]] <= wdat[p];
      end
    end
  end

  // Scoreboard: writes clear, a reservation in the same cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (grant[p])
          pending[wsel[p]] <= 1'b0;
      end
      if (pend_set && pend_sel != '0)
        pending[pend_sel] <= 1'b1;
    end
  end

  // One-cycle acks and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack <= '0;
      rr_ptr <= '0;
    end else begin
      wr_ack <= grant;
      rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp
// against a behavioural model, with and without bypass.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int SW = 5;
  localparam int RP = 2;
  localparam int WP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [RP*SW-1:0] rd_sel = '0;
  logic [RP*DW-1:0] rd_data;
  logic [RP*DW-1:0] rd_data_nb;
  logic [RP-1:0]    rd_pending;
  logic [RP-1:0]    rd_pending_nb;
  logic [WP-1:0]    wr_req = '0;
  logic [WP*SW-1:0] wr_sel = '0;
  logic [WP*DW-1:0] wr_data = '0;
  logic [WP-1:0]    wr_ack;
  logic [WP-1:0]    wr_ack_nb;
  logic             pend_set = 1'b0;
  logic [SW-1:0]    pend_sel = '0;
  logic [NR-1:0]    pending;
  logic [NR-1:0]    pending_nb;

  always #5 clk = ~clk;

  reg_file_mp #(.bypass(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_pending(rd_pending),
    .wr_req(wr_req), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .pend_set(pend_set), .pend_sel(pend_sel),
    .pending(pending)
  );

  reg_file_mp #(.bypass(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_sel(rd_sel), .rd_data(rd_data_nb),
    .rd_pending(rd_pending_nb),
    .wr_req(wr_req), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ack(wr_ack_nb),
    .pend_set(pend_set), .pend_sel(pend_sel),
    .pending(pending_nb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] mregs [NR];
  logic [31:0] mpend;
  logic [1:0]  mack;
  logic [1:0]  mgrant;
  int          mrr;

  function automatic logic [4:0] ws(int p);
    return wr_sel[p*SW +: SW];
  endfunction

  task automatic model_reset();
    foreach (mregs[r]) mregs[r] = '0;
    mpend = '0;
    mack  = '0;
    mrr   = 0;
  endtask

  function automatic bit is_elig(int p);
    return rst && wr_req[p] && !mack[p];
  endfunction

  // scan ports starting at mrr; first claimant of a register wins
  task automatic model_grant();
    bit [31:0] claimed = '0;
    mgrant = '0;
    for (int k = 0; k < WP; k++) begin
      int p = (mrr + k) % WP;
      if (is_elig(p) && !claimed[ws(p)]) begin
        claimed[ws(p)] = 1'b1;
        mgrant[p] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(int i, bit byp);
    logic [4:0] s = rd_sel[i*SW +: SW];
    if (s == 0) return '0;
    if (byp)
      for (int p = 0; p < WP; p++)
        if (mgrant[p] && ws(p) == s)
          return wr_data[p*DW +: DW];
    return mregs[s];
  endfunction

  task automatic model_step();
    bit done = 1'b0;
    for (int s = 0; s < NR; s++) begin
      int n = 0;
      int w = 0;
      for (int p = 0; p < WP; p++) begin
        if (is_elig(p) && ws(p) == s) n++;
        if (mgrant[p] && ws(p) == s) w = p;
      end
      if (!done && n > 1) begin
        mrr  = (w + 1) % WP;
        done = 1'b1;
      end
    end
    for (int p = 0; p < WP; p++) begin
      if (mgrant[p]) begin
        if (ws(p) != 0) mregs[ws(p)] = wr_data[p*DW +: DW];
        mpend[ws(p)] = 1'b0;
      end
    end
    if (pend_set && pend_sel != 0) mpend[pend_sel] = 1'b1;
    mack = mgrant;
  endtask

  task automatic wr(int p, bit req, logic [4:0] s,
                    logic [31:0] d);
    wr_req[p] = req;
    wr_sel[p*SW +: SW] = s;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(int i, logic [4:0] s);
    rd_sel[i*SW +: SW] = s;
  endtask

  // called just after a falling edge with inputs driven
  task automatic cyc();
    logic [4:0] s0;
    logic [4:0] s1;
    #1;
    model_grant();
    s0 = rd_sel[0 +: SW];
    s1 = rd_sel[SW +: SW];
    check("ack", 64'(wr_ack), 64'(mack));
    check("ack_nb", 64'(wr_ack_nb), 64'(mack));
    check("pending", 64'(pending), 64'(mpend));
    check("pending_nb", 64'(pending_nb), 64'(mpend));
    check("rd_byp", rd_data, {exp_rd(1, 1'b1), exp_rd(0, 1'b1)});
    check("rd_nb", rd_data_nb, {exp_rd(1, 1'b0), exp_rd(0, 1'b0)});
    check("rd_pend", 64'(rd_pending), 64'({mpend[s1], mpend[s0]}));
    check("rd_pend_nb", 64'(rd_pending_nb),
          64'({mpend[s1], mpend[s0]}));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("rst_ack", 64'(wr_ack), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_rd", rd_data, 64'd0);
    check("rst_rd_nb", rd_data_nb, 64'd0);
    #1 rst = 1'b1;
  endtask

  int a0;
  int a1;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rd(0, 5'd5);
    cyc();
    rst = 1'b1;

    // reset check
    wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    check("r5_written", 64'(rd_data_nb[31:0]), 64'hDEADBEEF);
    do_reset();
    cyc();
    check("r5_after_rst", 64'(rd_data_nb[31:0]), 64'd0);
    wr(0, 1'b1, 5'd5, 32'h1);
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    cyc();
    check("r5_post", 64'(rd_data_nb[31:0]), 64'h1);

    // basic write and bypass
    wr(0, 1'b1, 5'd3, 32'h12345678);
    rd(0, 5'd3);
    #1;
    check("byp_same", 64'(rd_data[31:0]), 64'h12345678);
    check("nb_same", 64'(rd_data_nb[31:0]), 64'd0);
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    check("basic_ack", 64'(wr_ack[0]), 64'd1);
    check("nb_next", 64'(rd_data_nb[31:0]), 64'h12345678);
    cyc();

    // r0 stays zero, never pending
    wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    rd(0, 5'd0);
    pend_set = 1'b1;
    pend_sel = 5'd0;
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    pend_set = 1'b0;
    check("r0_ack", 64'(wr_ack[0]), 64'd1);
    check("r0_pend", 64'(pending[0]), 64'd0);
    check("r0_rd", 64'(rd_data[31:0]), 64'd0);
    cyc();

    // round-robin conflict on r7
    wr(0, 1'b1, 5'd7, 32'hA);
    wr(1, 1'b1, 5'd7, 32'hB);
    rd(0, 5'd7);
    #1;
    check("rr1_byp", 64'(rd_data[31:0]), 64'hA);
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    wr(1, 1'b0, 5'd0, 32'd0);
    check("rr1_ack", 64'(wr_ack), 64'd1);
    cyc();
    wr(0, 1'b1, 5'd7, 32'hA);
    wr(1, 1'b1, 5'd7, 32'hB);
    #1;
    check("rr2_byp", 64'(rd_data[31:0]), 64'hB);
    cyc();
    check("rr2_ack", 64'(wr_ack), 64'd2);
    a0 = 0;
    a1 = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      a0 += int'(wr_ack[0]);
      a1 += int'(wr_ack[1]);
    end
    check("rr_p0_served", 64'(a0 > 2), 64'd1);
    check("rr_p1_served", 64'(a1 > 2), 64'd1);
    wr(0, 1'b0, 5'd0, 32'd0);
    wr(1, 1'b0, 5'd0, 32'd0);
    cyc();
    cyc();

    // no conflict: both granted together
    wr(0, 1'b1, 5'd2, 32'h2);
    wr(1, 1'b1, 5'd4, 32'h4);
    rd(0, 5'd2);
    rd(1, 5'd4);
    cyc();
    wr(0, 1'b0, 5'd0, 32'd0);
    wr(1, 1'b0, 5'd0, 32'd0);
    check("nc_ack", 64'(wr_ack), 64'd3);
    check("nc_rd", rd_data_nb, {32'h4, 32'h2});
    cyc();

    // scoreboard
    pend_set = 1'b1;
    pend_sel = 5'd9;
    rd(0, 5'd9);
    cyc();
    pend_set = 1'b0;
    check("sb_set", 64'(pending[9]), 64'd1);
    check("sb_rdpend", 64'(rd_pending[0]), 64'd1);
    wr(1, 1'b1, 5'd9, 32'h99);
    cyc();
    wr(1, 1'b0, 5'd0, 32'd0);
    check("sb_clear", 64'(pending[9]), 64'd0);
    cyc();
    pend_set = 1'b1;
    wr(1, 1'b1, 5'd9, 32'h77);
    cyc();
    pend_set = 1'b0;
    wr(1, 1'b0, 5'd0, 32'd0);
    check("sb_both_pend", 64'(pending[9]), 64'd1);
    check("sb_both_data", 64'(rd_data_nb[31:0]), 64'h77);
    cyc();

    // randomized traffic with a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < WP; p++) begin
        if (!wr_req[p] || mack[p]) begin
          if ($urandom_range(2) != 0)
            wr(p, 1'b1, 5'($urandom_range(7)), $urandom);
          else
            wr(p, 1'b0, 5'd0, 32'd0);
        end
      end
      rd(0, 5'($urandom_range(15)));
      rd(1, 5'($urandom_range(15)));
      pend_set = ($urandom_range(3) == 0);
      pend_sel = 5'($urandom_range(15));
      if (c == 700) do_reset();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
